// File: rtl/serial_packet_echo_if.sv
// Serial link bundle between the UART receiver/transmitter and the packet echo block,
// plus the host-visible status outputs.
interface serial_packet_echo_if;
  logic        rxReady;
  logic [7:0]  rxData;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic [7:0]  readdata;
  logic [15:0] pkt_count;
  logic [7:0]  overrun_count;
  logic        rx_drop;

  modport master (
    output rxReady, rxData, txBusy,
    input  txStart, txData, readdata, pkt_count, overrun_count, rx_drop
  );

  modport slave (
    input  rxReady, rxData, txBusy,
    output txStart, txData, readdata, pkt_count, overrun_count, rx_drop
  );
endinterface

// File: rtl/serial_packet_echo.sv
// Collects LEN received bytes and echoes them through the UART transmitter, in arrival or
// reversed order. Define CHECKSUM_EN to append an 8-bit modular sum byte to each echo.
module serial_packet_echo #(
  parameter int LEN     = 4,
  parameter int REVERSE = 0,
  parameter int TIMEOUT = 1000000
) (
  input logic             clk,
  input logic             reset,
  serial_packet_echo_if.slave bus
);
  localparam int IDX_W = $clog2(LEN + 1);
  localparam int AW    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
`ifdef CHECKSUM_EN
  localparam int LAST_K = LEN;
`else
  localparam int LAST_K = LEN - 1;
`endif

  typedef enum logic [1:0] {
    READ      = 2'd0,
    WAIT_IDLE = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e           state_q;
  logic [7:0]       buf_q [LEN];
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] k_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic [7:0]       readdata_q;
  logic [15:0]      pkt_count_q;
  logic [7:0]       overrun_q;
  logic             rx_drop_q;

  logic             expire_d;
  logic             buf_we_d;
  logic [AW-1:0]    buf_wa_d;
  logic [7:0]       tx_byte_d;
`ifdef CHECKSUM_EN
  logic [7:0]       sum_q;
  logic [7:0]       sum_d;
`endif

  function automatic logic [AW-1:0] to_addr(input logic [IDX_W-1:0] i);
    return AW'(i);
  endfunction

  // Transmit order: byte k of the echo comes from buf[LEN-1-k] when reversing.
  function automatic logic [AW-1:0] tx_addr(input logic [IDX_W-1:0] k);
    if (REVERSE != 0) begin
      return AW'(32'(LEN - 1) - 32'(k));
    end else begin
      return AW'(k);
    end
  endfunction

  // Timeout expiry, buffer write port and next transmit byte.
  always_comb begin
    expire_d  = 1'b0;
    buf_we_d  = 1'b0;
    buf_wa_d  = {AW{1'b0}};
    tx_byte_d = buf_q[tx_addr(k_q)];
    if ((TIMEOUT != 0) && (idx_q != {IDX_W{1'b0}}) && (to_cnt_q == TO_W'(TIMEOUT))) begin
      expire_d = 1'b1;
    end else begin
      expire_d = 1'b0;
    end
    // A byte arriving on the expiry cycle starts a fresh packet at buf[0].
    if (!reset && (state_q == READ) && bus.rxReady) begin
      buf_we_d = 1'b1;
      buf_wa_d = expire_d ? {AW{1'b0}} : to_addr(idx_q);
    end else begin
      buf_we_d = 1'b0;
      buf_wa_d = {AW{1'b0}};
    end
`ifdef CHECKSUM_EN
    if (expire_d || (idx_q == {IDX_W{1'b0}})) begin
      sum_d = bus.rxData;
    end else begin
      sum_d = sum_q + bus.rxData;
    end
    if (k_q == IDX_W'(LEN)) begin
      tx_byte_d = sum_q;
    end else begin
      tx_byte_d = buf_q[tx_addr(k_q)];
    end
`endif
  end

  // Packet buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we_d) begin
      buf_q[buf_wa_d] <= bus.rxData;
    end
  end

  // Receive/transmit FSM with registered outputs and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= READ;
      idx_q       <= {IDX_W{1'b0}};
      k_q         <= {IDX_W{1'b0}};
      to_cnt_q    <= {TO_W{1'b0}};
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      readdata_q  <= 8'h00;
      pkt_count_q <= 16'h0000;
      overrun_q   <= 8'h00;
      rx_drop_q   <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      tx_start_q <= 1'b0;
      rx_drop_q  <= 1'b0;
      if ((state_q != READ) && bus.rxReady && (overrun_q != 8'hFF)) begin
        overrun_q <= overrun_q + 8'd1;
      end
      case (state_q)
        READ: begin
          if (expire_d) begin
            rx_drop_q <= 1'b1;
          end
          if (bus.rxReady) begin
            to_cnt_q <= {TO_W{1'b0}};
`ifdef CHECKSUM_EN
            sum_q    <= sum_d;
`endif
            if (expire_d) begin
              idx_q <= IDX_W'(1'b1);
            end else if (idx_q == IDX_W'(LEN - 1)) begin
              readdata_q <= (LEN == 1) ? bus.rxData : buf_q[0];
              idx_q      <= {IDX_W{1'b0}};
              k_q        <= {IDX_W{1'b0}};
              state_q    <= WAIT_IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1'b1);
            end
          end else if (expire_d) begin
            idx_q    <= {IDX_W{1'b0}};
            to_cnt_q <= {TO_W{1'b0}};
          end else if ((TIMEOUT != 0) && (idx_q != {IDX_W{1'b0}})) begin
            to_cnt_q <= to_cnt_q + TO_W'(1'b1);
          end
        end
        WAIT_IDLE: begin
          if (!bus.txBusy) begin
            tx_data_q  <= tx_byte_d;
            tx_start_q <= 1'b1;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (bus.txBusy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.txBusy) begin
            if (k_q < IDX_W'(LAST_K)) begin
              k_q     <= k_q + IDX_W'(1'b1);
              state_q <= WAIT_IDLE;
            end else begin
              pkt_count_q <= pkt_count_q + 16'd1;
              idx_q       <= {IDX_W{1'b0}};
              to_cnt_q    <= {TO_W{1'b0}};
              state_q     <= READ;
            end
          end
        end
        default: begin
          state_q <= READ;
        end
      endcase
    end
  end

  assign bus.txStart       = tx_start_q;
  assign bus.txData        = tx_data_q;
  assign bus.readdata      = readdata_q;
  assign bus.pkt_count     = pkt_count_q;
  assign bus.overrun_count = overrun_q;
  assign bus.rx_drop       = rx_drop_q;
endmodule

// File: tb/tb_serial_packet_echo.sv
// Directed bench for serial_packet_echo: forward and reversed instances share rx stimulus;
// each has its own transmitter model and expected-byte queue.
module tb_serial_packet_echo;
  localparam int LEN = 4;
`ifdef CHECKSUM_EN
  localparam int NTX = LEN + 1;
`else
  localparam int NTX = LEN;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_packet_echo_if if0();
  serial_packet_echo_if if1();

  serial_packet_echo #(.LEN(LEN), .REVERSE(0), .TIMEOUT(50)) u_fwd (
    .clk(clk), .reset(reset), .bus(if0));
  serial_packet_echo #(.LEN(LEN), .REVERSE(1), .TIMEOUT(50)) u_rev (
    .clk(clk), .reset(reset), .bus(if1));

  int errors = 0;
  int checks = 0;
  logic hold_busy = 1'b0;
  int bcnt0 = 0, bcnt1 = 0;
  logic pend0 = 1'b0, pend1 = 1'b0;
  int n_start0 = 0, n_start1 = 0, n_drop0 = 0, n_drop1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [31:0] mexp0, mexp1;

  // Transmitter model: busy for 10 cycles starting one cycle after each txStart.
  always @(posedge clk) begin
    if (reset) begin
      pend0 <= 1'b0; pend1 <= 1'b0; bcnt0 <= 0; bcnt1 <= 0;
    end else begin
      pend0 <= if0.txStart;
      pend1 <= if1.txStart;
      if (pend0) bcnt0 <= 10; else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
      if (pend1) bcnt1 <= 10; else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
    end
  end
  assign if0.txBusy = hold_busy | (bcnt0 != 0);
  assign if1.txBusy = hold_busy | (bcnt1 != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every txStart pops the scoreboard; 0x100 marks an unexpected start.
  always @(negedge clk) begin
    if (!reset) begin
      if (if0.txStart) begin
        n_start0++;
        mexp0 = (q0.size() != 0) ? 32'(q0.pop_front()) : 32'h100;
        check("tx_fwd_byte", 32'(if0.txData), mexp0);
      end
      if (if1.txStart) begin
        n_start1++;
        mexp1 = (q1.size() != 0) ? 32'(q1.pop_front()) : 32'h100;
        check("tx_rev_byte", 32'(if1.txData), mexp1);
      end
      if (if0.rx_drop) n_drop0++;
      if (if1.rx_drop) n_drop1++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    if0.rxReady = 1'b1; if0.rxData = b;
    if1.rxReady = 1'b1; if1.rxData = b;
    @(negedge clk);
    if0.rxReady = 1'b0;
    if1.rxReady = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] p[4];
    logic [7:0] s;
    p = '{b0, b1, b2, b3};
    s = 8'h00;
    for (int i = 0; i < 4; i++) begin
      s = s + p[i];
      q0.push_back(p[i]);
      q1.push_back(p[3-i]);
    end
`ifdef CHECKSUM_EN
    q0.push_back(s);
    q1.push_back(s);
`endif
  endtask

  task automatic send4(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic wait_pkts(input int n);
    for (int i = 0; i < 3000 && !(if0.pkt_count == 16'(n) && if1.pkt_count == 16'(n)); i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    check("pkt_count_fwd", 32'(if0.pkt_count), 32'(n));
    check("pkt_count_rev", 32'(if1.pkt_count), 32'(n));
  endtask

  int d0, d1, base0, base1;

  initial begin
    if0.rxReady = 1'b0; if0.rxData = 8'h00;
    if1.rxReady = 1'b0; if1.rxData = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txStart", 32'(if0.txStart), 32'd0);
    check("rst_txData", 32'(if0.txData), 32'd0);
    check("rst_readdata", 32'(if0.readdata), 32'd0);
    check("rst_pkt_count", 32'(if0.pkt_count), 32'd0);
    check("rst_overrun", 32'(if0.overrun_count), 32'd0);
    check("rst_rx_drop", 32'(if0.rx_drop), 32'd0);
    reset = 1'b0;

    push_exp(8'h11, 8'h22, 8'h33, 8'h44);
    send4(8'h11, 8'h22, 8'h33, 8'h44);
    wait_pkts(1);
    check("readdata_fwd_p1", 32'(if0.readdata), 32'h11);
    check("readdata_rev_p1", 32'(if1.readdata), 32'h11);
    check("starts_fwd_p1", 32'(n_start0), 32'(NTX));
    check("starts_rev_p1", 32'(n_start1), 32'(NTX));

    push_exp(8'hFF, 8'hFF, 8'h01, 8'h01);
    send4(8'hFF, 8'hFF, 8'h01, 8'h01);
    wait_pkts(2);

    // Partial packet dropped by the 50-cycle timeout.
    d0 = n_drop0; d1 = n_drop1;
    send_byte(8'hA0); send_byte(8'hA1);
    repeat (60) @(negedge clk);
    check("drop_fwd_partial", 32'(n_drop0), 32'(d0 + 1));
    check("drop_rev_partial", 32'(n_drop1), 32'(d1 + 1));
    check("no_start_on_drop", 32'(n_start0), 32'(2 * NTX));
    push_exp(8'h01, 8'h02, 8'h03, 8'h04);
    send4(8'h01, 8'h02, 8'h03, 8'h04);
    wait_pkts(3);
    check("readdata_p3", 32'(if0.readdata), 32'h01);

    // Byte arriving on the expiry cycle becomes buf[0] of a new packet.
    d0 = n_drop0;
    send_byte(8'hB0);
    repeat (49) @(negedge clk);
    push_exp(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    send4(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    wait_pkts(4);
    check("drop_coincident", 32'(n_drop0), 32'(d0 + 1));
    check("readdata_coinc", 32'(if1.readdata), 32'hC0);

    push_exp(8'h55, 8'h66, 8'h77, 8'h88);
    send4(8'h55, 8'h66, 8'h77, 8'h88);
    send_byte(8'hEE); send_byte(8'hEE); send_byte(8'hEE);
    wait_pkts(5);
    check("overrun_3", 32'(if0.overrun_count), 32'd3);

    hold_busy = 1'b1;
    push_exp(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    send4(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    for (int i = 0; i < 300; i++) send_byte(8'hEE);
    check("overrun_sat_fwd", 32'(if0.overrun_count), 32'd255);
    check("overrun_sat_rev", 32'(if1.overrun_count), 32'd255);
    hold_busy = 1'b0;
    wait_pkts(6);
    check("readdata_p6", 32'(if0.readdata), 32'h5A);

    // Reset while waiting for busy on the third byte.
    base0 = n_start0;
    push_exp(8'h12, 8'h34, 8'h56, 8'h78);
    send4(8'h12, 8'h34, 8'h56, 8'h78);
    for (int i = 0; i < 500 && n_start0 < base0 + 3; i++) @(negedge clk);
    check("third_start_seen", 32'(n_start0), 32'(base0 + 3));
    reset = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    check("rst_mid_txStart", 32'(if0.txStart), 32'd0);
    check("rst_mid_pkt", 32'(if0.pkt_count), 32'd0);
    check("rst_mid_overrun", 32'(if1.overrun_count), 32'd0);
    reset = 1'b0;
    base0 = n_start0; base1 = n_start1;
    push_exp(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    send4(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    wait_pkts(1);
    check("readdata_after_rst", 32'(if0.readdata), 32'h9A);
    check("starts_after_rst", 32'(n_start0), 32'(base0 + NTX));
    check("starts_rev_after_rst", 32'(n_start1), 32'(base1 + NTX));
    check("queue_fwd_empty", 32'(q0.size()), 32'd0);
    check("queue_rev_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
